spi_sync_deserializer: RTL and testbench

//  SPI mode-0 slave datapath fed by per-pin negedge synchronizers on CSB, SCLK and MOSI.
//  All SPI inputs are already in the i_clk domain and change only on i_clk falling edges.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_edge_det.sv | 22 ++
 rtl/spi_sync_deserializer.sv | 181 ++++++++++++++++++
 tb/tb_spi_sync_deserializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 slave deserializer.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Bit counter must hold 0..DATA_W.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// One-bit history register with rise/fall decode against the live input.
module spi_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic hist;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) hist <= RST_VAL;
    else       hist <= sig;
  end

  assign rise = sig & ~hist;
  assign fall = ~sig & hist;

endmodule

// File: rtl/spi_sync_deserializer.sv
// SPI mode-0 slave datapath: RX deserializer plus optional MISO serializer.
// Define SPI_TX_EN to build the MISO path, TX holding register and underrun pulse.
module spi_sync_deserializer
  import spi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_csb_sync,
  input  logic              i_sclk_sync,
  input  logic              i_mosi_sync,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_frame_start,
  output logic              o_frame_end,
  output logic              o_frame_abort,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic              o_tx_underrun
);

  localparam int                CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  spi_edge_det #(.RST_VAL(1'b0)) u_sclk_edge (
    .clk  (i_clk),
    .rstb (i_rstb),
    .sig  (i_sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_det #(.RST_VAL(1'b1)) u_csb_edge (
    .clk  (i_clk),
    .rstb (i_rstb),
    .sig  (i_csb_sync),
    .rise (csb_rise),
    .fall (csb_fall)
  );

  state_t            state, state_nxt;
  logic              armed;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
  logic              frame_go, frame_stop;
  logic              sample_edge, shift_edge, sample_ev, shift_ev, word_done;

  assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
  assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;

  always_comb begin
    state_nxt  = state;
    frame_go   = 1'b0;
    frame_stop = 1'b0;
    case (state)
      IDLE: begin
        if (csb_fall && armed) begin
          state_nxt = SHIFT;
          frame_go  = 1'b1;
        end
      end
      SHIFT: begin
        if (csb_rise) begin
          state_nxt  = IDLE;
          frame_stop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CSB rise outranks any SCLK edge seen in the same cycle.
  assign sample_ev = (state == SHIFT) && !csb_rise && sample_edge;
  assign shift_ev  = (state == SHIFT) && !csb_rise && shift_edge;
  assign word_done = sample_ev && (bit_cnt == LAST_BIT);

  assign rx_shift_nxt = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], i_mosi_sync}
                                         : {i_mosi_sync, rx_shift[DATA_W-1:1]};

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state         <= IDLE;
      armed         <= 1'b0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_frame_abort <= 1'b0;
    end else begin
      state         <= state_nxt;
      o_rx_valid    <= word_done;
      o_frame_start <= frame_go;
      o_frame_end   <= frame_stop && (bit_cnt == '0);
      o_frame_abort <= frame_stop && (bit_cnt != '0);
      // Only a high CSB arms the FSM, so a frame cut by reset is ignored to its end.
      if (i_csb_sync) armed <= 1'b1;
      if (frame_stop) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (sample_ev) begin
        rx_shift <= rx_shift_nxt;
        if (word_done) begin
          bit_cnt   <= '0;
          o_rx_data <= rx_shift_nxt;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef SPI_TX_EN

  logic [DATA_W-1:0] hold_data, tx_shift, tx_next;
  logic              hold_full, miso_q, underrun_q;
  logic              tx_load, tx_advance, capture;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  assign capture    = !hold_full && i_tx_valid;
  assign tx_load    = frame_go || (shift_ev && (bit_cnt == '0));
  assign tx_advance = shift_ev && (bit_cnt != '0);
  assign tx_next    = (MSB_FIRST != 0) ? (tx_shift << 1) : (tx_shift >> 1);

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      hold_data  <= '0;
      hold_full  <= 1'b0;
      tx_shift   <= '0;
      miso_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= tx_load && !hold_full;
      if (frame_stop) begin
        tx_shift <= '0;
        miso_q   <= 1'b0;
      end else if (tx_load) begin
        tx_shift <= hold_full ? hold_data : '0;
        miso_q   <= hold_full ? first_bit(hold_data) : 1'b0;
      end else if (tx_advance) begin
        tx_shift <= tx_next;
        miso_q   <= first_bit(tx_next);
      end
      // A capture only happens while empty, so a coincident load has already underrun.
      if (capture) begin
        hold_data <= i_tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign o_tx_ready    = !hold_full;
  assign o_miso        = miso_q;
  assign o_miso_oe     = (state == SHIFT);
  assign o_tx_underrun = underrun_q;

`else

  logic unused_tx;
  assign unused_tx     = ^{i_tx_data, i_tx_valid, shift_ev};
  assign o_tx_ready    = 1'b0;
  assign o_miso        = 1'b0;
  assign o_miso_oe     = 1'b0;
  assign o_tx_underrun = 1'b0;

`endif

endmodule

// File: tb/tb_spi_sync_deserializer.sv
// Directed bench for spi_sync_deserializer with a queue-based frame model checked every cycle.
module tb_spi_sync_deserializer;

  localparam int DW = 16;
`ifdef SPI_TX_EN
  localparam bit TX_EN = 1'b1;
`else
  localparam bit TX_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstb, csb, sclk, mosi, tx_valid;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] o_rx_data;
  logic          o_rx_valid, o_frame_start, o_frame_end, o_frame_abort;
  logic          o_tx_ready, o_miso, o_miso_oe, o_tx_underrun;

  always #5 clk = ~clk;

  spi_sync_deserializer #(.DATA_W(DW), .MSB_FIRST(1)) dut (
    .i_clk         (clk),
    .i_rstb        (rstb),
    .i_csb_sync    (csb),
    .i_sclk_sync   (sclk),
    .i_mosi_sync   (mosi),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .o_frame_start (o_frame_start),
    .o_frame_end   (o_frame_end),
    .o_frame_abort (o_frame_abort),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_miso        (o_miso),
    .o_miso_oe     (o_miso_oe),
    .o_tx_underrun (o_tx_underrun)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: bits collected in queues, words packed when DW bits arrive.
  bit            m_active, m_armed, m_prev_csb, m_prev_sclk, m_hold_full, m_miso;
  logic [DW-1:0] m_rx_data, m_hold_data;
  bit            rxq[$];
  bit            txq[$];
  bit            e_rxv, e_start, e_end, e_abort, e_under;

  int            n_rxv, n_start, n_end, n_abort, n_under;
  logic [DW-1:0] rx_log[$];

  always @(posedge clk) begin
    bit            load, ready0;
    logic [DW-1:0] word;
    e_rxv = 0; e_start = 0; e_end = 0; e_abort = 0; e_under = 0; load = 0;
    if (!rstb) begin
      m_active = 0; m_armed = 0; m_prev_csb = 1; m_prev_sclk = 0;
      rxq.delete(); txq.delete();
      m_rx_data = '0; m_hold_full = 0; m_hold_data = '0; m_miso = 0;
    end else begin
      ready0 = !m_hold_full;
      if (!m_active) begin
        if (!csb && m_prev_csb && m_armed) begin
          m_active = 1; e_start = 1; load = 1;
        end
      end else if (csb && !m_prev_csb) begin
        m_active = 0;
        if (rxq.size() == 0) e_end = 1; else e_abort = 1;
        rxq.delete(); txq.delete(); m_miso = 0;
      end else if (sclk && !m_prev_sclk) begin
        rxq.push_back(mosi);
        if (rxq.size() == DW) begin
          word = '0;
          foreach (rxq[i]) word = {word[DW-2:0], rxq[i]};
          m_rx_data = word; e_rxv = 1; rxq.delete();
        end
      end else if (!sclk && m_prev_sclk) begin
        if (rxq.size() == 0) load = 1;
        else m_miso = (txq.size() > 0) ? txq.pop_front() : 1'b0;
      end
      if (TX_EN && load) begin
        txq.delete();
        if (m_hold_full) begin
          for (int i = DW - 1; i >= 0; i--) txq.push_back(m_hold_data[i]);
          m_miso = txq.pop_front();
          m_hold_full = 0;
        end else begin
          m_miso = 0; e_under = 1;
        end
      end
      if (TX_EN && ready0 && tx_valid) begin
        m_hold_full = 1; m_hold_data = tx_data;
      end
      if (csb) m_armed = 1;
      m_prev_csb = csb; m_prev_sclk = sclk;
    end
    #1;
    chk("rx_data",     o_rx_data,     m_rx_data);
    chk("rx_valid",    o_rx_valid,    e_rxv);
    chk("frame_start", o_frame_start, e_start);
    chk("frame_end",   o_frame_end,   e_end);
    chk("frame_abort", o_frame_abort, e_abort);
    chk("tx_ready",    o_tx_ready,    TX_EN ? !m_hold_full : 1'b0);
    chk("miso",        o_miso,        TX_EN ? m_miso : 1'b0);
    chk("miso_oe",     o_miso_oe,     TX_EN ? m_active : 1'b0);
    chk("tx_underrun", o_tx_underrun, e_under);
    if (o_rx_valid === 1'b1) begin n_rxv++; rx_log.push_back(o_rx_data); end
    if (o_frame_start === 1'b1) n_start++;
    if (o_frame_end === 1'b1)   n_end++;
    if (o_frame_abort === 1'b1) n_abort++;
    if (o_tx_underrun === 1'b1) n_under++;
  end

  logic [31:0] miso_cap;

  task automatic clear_counts();
    n_rxv = 0; n_start = 0; n_end = 0; n_abort = 0; n_under = 0;
    rx_log.delete();
  endtask

  task automatic start_frame();
    @(negedge clk); csb = 1'b0; miso_cap = '0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); sclk = 1'b0; mosi = b;
    @(negedge clk);
    @(negedge clk); miso_cap = {miso_cap[30:0], o_miso}; sclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int nbits);
    for (int i = DW - 1; i > DW - 1 - nbits; i--) send_bit(w[i]);
  endtask

  // SCLK falls together with CSB rising, so the last fall is never acted on.
  task automatic end_frame();
    @(negedge clk); sclk = 1'b0; csb = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    rstb = 1'b0; csb = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data",  o_rx_data,  16'h0000);
    chk("rst_rx_valid", o_rx_valid, 1'b0);
    chk("rst_tx_ready", o_tx_ready, TX_EN);
    chk("rst_miso_oe",  o_miso_oe,  1'b0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: single word 0xA5C3, rx_valid exactly one cycle after last rise is sampled
    clear_counts();
    w = 16'hA5C3;
    start_frame();
    send_word(w, 15);
    @(negedge clk); sclk = 1'b0; mosi = w[0];
    @(negedge clk);
    @(negedge clk); sclk = 1'b1;
    @(posedge clk); #1;
    chk("t1_rxv_lat",  o_rx_valid, 1'b1);
    chk("t1_rx_data",  o_rx_data,  16'hA5C3);
    @(posedge clk); #1;
    chk("t1_rxv_pulse", o_rx_valid, 1'b0);
    end_frame();
    chk("t1_start_cnt", n_start, 1);
    chk("t1_rxv_cnt",   n_rxv,   1);
    chk("t1_end_cnt",   n_end,   1);

    // Test 2: TX word 0x1234 queued before CSB fall comes back on MISO MSB first
    @(negedge clk); tx_data = 16'h1234; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    chk("t2_ready_full", o_tx_ready, 1'b0);
    clear_counts();
    start_frame();
    chk("t2_ready_load", o_tx_ready, TX_EN);
    send_word(16'h0F0F, 16);
    end_frame();
    chk("t2_miso_word", miso_cap[15:0], TX_EN ? 16'h1234 : 16'h0000);
    chk("t2_rx_word",   rx_log.size() > 0 ? rx_log[0] : 16'hxxxx, 16'h0F0F);
    chk("t2_underrun",  n_under, 0);

    // Test 3: two back-to-back words, no TX data
    clear_counts();
    start_frame();
    send_word(16'h0001, 16);
    send_word(16'hFFFF, 16);
    end_frame();
    chk("t3_rxv_cnt",   n_rxv, 2);
    chk("t3_word0",     rx_log.size() > 0 ? rx_log[0] : 16'hxxxx, 16'h0001);
    chk("t3_word1",     rx_log.size() > 1 ? rx_log[1] : 16'hxxxx, 16'hFFFF);
    chk("t3_underrun",  n_under, TX_EN ? 2 : 0);
    chk("t3_miso_zero", miso_cap, 32'h0);
    chk("t3_end_cnt",   n_end, 1);

    // Test 4: abort after 5 bits, then a clean 0xBEEF frame
    clear_counts();
    start_frame();
    send_word(16'hBEEF, 5);
    end_frame();
    chk("t4_abort_cnt", n_abort, 1);
    chk("t4_rxv_none",  n_rxv, 0);
    chk("t4_end_none",  n_end, 0);
    clear_counts();
    start_frame();
    send_word(16'hBEEF, 16);
    end_frame();
    chk("t4_rxv_cnt",   n_rxv, 1);
    chk("t4_word",      rx_log.size() > 0 ? rx_log[0] : 16'hxxxx, 16'hBEEF);
    chk("t4_end_cnt",   n_end, 1);

    // Test 5: reset mid-frame, remainder of that frame is ignored
    clear_counts();
    w = 16'h5A5A;
    start_frame();
    send_word(w, 7);
    @(negedge clk); rstb = 1'b0;
    @(negedge clk);
    chk("t5_rst_rx_data", o_rx_data, 16'h0000);
    rstb = 1'b1;
    for (int i = 8; i >= 0; i--) send_bit(w[i]);
    end_frame();
    chk("t5_rxv_none",   n_rxv, 0);
    chk("t5_end_none",   n_end, 0);
    chk("t5_abort_none", n_abort, 0);
    clear_counts();
    start_frame();
    send_word(16'h5A5A, 16);
    end_frame();
    chk("t5_start_cnt", n_start, 1);
    chk("t5_rxv_cnt",   n_rxv, 1);
    chk("t5_word",      rx_log.size() > 0 ? rx_log[0] : 16'hxxxx, 16'h5A5A);

    // Test 6: CSB rises in the same cycle as the 16th SCLK rise
    clear_counts();
    w = 16'hC3C3;
    start_frame();
    send_word(w, 15);
    @(negedge clk); sclk = 1'b0; mosi = w[0];
    @(negedge clk);
    @(negedge clk); sclk = 1'b1; csb = 1'b1;
    @(negedge clk);
    @(negedge clk); sclk = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_abort_cnt", n_abort, 1);
    chk("t6_rxv_none",  n_rxv, 0);
    chk("t6_end_none",  n_end, 0);
    chk("t6_rx_held",   o_rx_data, 16'h5A5A);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
